// File: rtl/mmio_fifo_port.sv
// Depth-configurable FIFO behind an MMIO register window: DATA push/pop, STATUS,
// CONTROL (flush / flag clear) and non-destructive PEEK, with 1-cycle read responses.
module mmio_fifo_port #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0020,
  parameter int unsigned TID_W     = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  input  logic [15:0]                wr_addr,
  input  logic [63:0]                wr_data,
  input  logic                       rd_valid,
  input  logic [15:0]                rd_addr,
  input  logic [TID_W-1:0]           rd_tid,
  output logic                       rd_resp_valid,
  output logic [TID_W-1:0]           rd_resp_tid,
  output logic [63:0]                rd_resp_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_STATUS = 3'd2,
    REG_CTRL   = 3'd4,
    REG_PEEK   = 3'd6
  } reg_off_e;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf, r_udf;
  logic              r_resp_valid;
  logic [TID_W-1:0]  r_resp_tid;
  logic [63:0]       r_resp_data;

  logic        w_wr_hit, w_rd_hit;
  logic        w_push, w_pop_req, w_ctrl;
  logic        w_empty, w_full;
  logic        w_pop_ok, w_push_ok;
  logic        w_flush, w_clr;
  logic        w_set_ovf, w_set_udf;
  logic [63:0] w_head, w_status, w_rd_data;

  assign w_wr_hit  = wr_valid && (wr_addr[15:3] == BASE_ADDR[15:3]);
  assign w_rd_hit  = rd_valid && (rd_addr[15:3] == BASE_ADDR[15:3]);
  assign w_push    = w_wr_hit && (wr_addr[2:0] == REG_DATA);
  assign w_ctrl    = w_wr_hit && (wr_addr[2:0] == REG_CTRL);
  assign w_pop_req = w_rd_hit && (rd_addr[2:0] == REG_DATA);

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop_ok  = w_pop_req && !w_empty;
  // A successful same-cycle pop frees the slot, so a push into a full FIFO is accepted then.
  assign w_push_ok = w_push && (!w_full || w_pop_ok);
  assign w_flush   = w_ctrl && wr_data[0];
  assign w_clr     = w_ctrl && wr_data[1];
  assign w_set_ovf = w_push && !w_push_ok;
  assign w_set_udf = w_pop_req && w_empty;

  always_comb begin
    w_head = '0;
    w_head[DATA_W-1:0] = r_mem[r_rptr];
  end

  always_comb begin
    w_status        = '0;
    w_status[15:0]  = 16'(r_count);
    w_status[16]    = w_empty;
    w_status[17]    = w_full;
    w_status[18]    = r_ovf;
    w_status[19]    = r_udf;
    w_status[47:32] = 16'(DEPTH);
  end

  always_comb begin
    w_rd_data = '0;
    case (rd_addr[2:0])
      REG_DATA:   w_rd_data = w_empty ? '0 : w_head;
      REG_STATUS: w_rd_data = w_status;
      REG_PEEK:   w_rd_data = w_empty ? '0 : w_head;
      default:    w_rd_data = '0;
    endcase
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) r_mem[r_wptr] <= wr_data[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_tid   <= '0;
      r_resp_data  <= '0;
    end else begin
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push_ok) r_wptr <= r_wptr + PW'(1);
        if (w_pop_ok)  r_rptr <= r_rptr + PW'(1);
        r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
      end
      r_ovf <= (r_ovf && !w_clr) || w_set_ovf;
      r_udf <= (r_udf && !w_clr) || w_set_udf;
      r_resp_valid <= w_rd_hit;
      if (w_rd_hit) begin
        r_resp_tid  <= rd_tid;
        r_resp_data <= w_rd_data;
      end
    end
  end

  assign rd_resp_valid = r_resp_valid;
  assign rd_resp_tid   = r_resp_tid;
  assign rd_resp_data  = r_resp_data;
  assign count         = r_count;

endmodule

// File: tb/tb_mmio_fifo_port.sv
// Directed bench for mmio_fifo_port with default parameters (DEPTH=8, BASE_ADDR=0x20).
module tb_mmio_fifo_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_addr = '0;
  logic [8:0]  rd_tid = '0;
  logic        rd_resp_valid;
  logic [8:0]  rd_resp_tid;
  logic [63:0] rd_resp_data;
  logic [3:0]  count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [63:0] ST_EMPTY = 64'h0000_0008_0001_0000;

  mmio_fifo_port #(.DATA_W(64), .DEPTH(8), .BASE_ADDR(16'h0020), .TID_W(9)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_tid(rd_tid),
    .rd_resp_valid(rd_resp_valid), .rd_resp_tid(rd_resp_tid),
    .rd_resp_data(rd_resp_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
    end
  endtask

  // Drives any combination of strobes for one cycle; response fields sampled #1 after the edge.
  task automatic cycle(input logic we, input logic [15:0] wa, input logic [63:0] wd,
                       input logic re, input logic [15:0] ra, input logic [8:0] tid,
                       output logic v, output logic [63:0] d, output logic [8:0] t);
    @(negedge clk);
    wr_valid = we; wr_addr = wa; wr_data = wd;
    rd_valid = re; rd_addr = ra; rd_tid = tid;
    @(posedge clk);
    #1;
    v = rd_resp_valid; d = rd_resp_data; t = rd_resp_tid;
    wr_valid = 1'b0; rd_valid = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    logic v; logic [63:0] x; logic [8:0] t;
    cycle(1'b1, a, d, 1'b0, 16'h0, 9'h0, v, x, t);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [63:0] exp);
    logic v; logic [63:0] x; logic [8:0] t;
    cycle(1'b0, 16'h0, 64'h0, 1'b1, a, 9'h0C3, v, x, t);
    check({tag, "_valid"}, 64'(v), 64'd1);
    check(tag, x, exp);
  endtask

  logic        v;
  logic [63:0] d;
  logic [8:0]  t;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(rd_resp_valid), 64'd0);
    check("rst_tid", 64'(rd_resp_tid), 64'd0);
    check("rst_data", rd_resp_data, 64'd0);
    @(negedge clk); rst = 1'b0;

    // 1: status after reset, latency and tid echo
    @(negedge clk);
    rd_valid = 1'b1; rd_addr = 16'h0022; rd_tid = 9'h1A5;
    #1 check("lat_before_edge", 64'(rd_resp_valid), 64'd0);
    @(posedge clk); #1;
    rd_valid = 1'b0;
    check("st0_valid", 64'(rd_resp_valid), 64'd1);
    check("st0_tid", 64'(rd_resp_tid), 64'h1A5);
    check("st0_data", rd_resp_data, ST_EMPTY);
    @(posedge clk); #1;
    check("st0_pulse", 64'(rd_resp_valid), 64'd0);

    // 2: fill, overflow, drain in order
    for (int i = 0; i < 9; i++) wr(16'h0020, 64'(8'hA1 + i));
    check("full_count", 64'(count), 64'd8);
    rd_chk("st_full_ovf", 16'h0022, 64'h0000_0008_0006_0008);
    for (int i = 0; i < 8; i++) rd_chk("pop_a", 16'h0020, 64'(8'hA1 + i));
    rd_chk("st_drained", 16'h0022, 64'h0000_0008_0005_0000);

    // 3: underflow then flag clear
    rd_chk("pop_empty", 16'h0020, 64'h0);
    rd_chk("st_udf", 16'h0022, 64'h0000_0008_000D_0000);
    wr(16'h0024, 64'h2);
    rd_chk("st_clr", 16'h0022, ST_EMPTY);

    // 4: peek is non-destructive
    wr(16'h0020, 64'h11);
    wr(16'h0020, 64'h22);
    rd_chk("peek1", 16'h0026, 64'h11);
    rd_chk("peek2", 16'h0026, 64'h11);
    rd_chk("pop_11", 16'h0020, 64'h11);
    check("count_after_pop", 64'(count), 64'd1);
    rd_chk("ctrl_reads_0", 16'h0024, 64'h0);

    // 5: push+pop while full
    for (int i = 0; i < 7; i++) wr(16'h0020, 64'(8'hB1 + i));
    check("full2", 64'(count), 64'd8);
    cycle(1'b1, 16'h0020, 64'h55, 1'b1, 16'h0020, 9'h033, v, d, t);
    check("fullpp_data", d, 64'h22);
    check("fullpp_tid", 64'(t), 64'h033);
    check("fullpp_count", 64'(count), 64'd8);
    rd_chk("st_fullpp", 16'h0022, 64'h0000_0008_0002_0008);
    for (int i = 0; i < 7; i++) rd_chk("pop_b", 16'h0020, 64'(8'hB1 + i));
    rd_chk("pop_55", 16'h0020, 64'h55);

    // 6: flush, reuse, out-of-window
    for (int i = 0; i < 5; i++) wr(16'h0020, 64'(8'hC1 + i));
    check("five", 64'(count), 64'd5);
    wr(16'h0024, 64'h1);
    check("flush_count", 64'(count), 64'd0);
    wr(16'h0020, 64'h77);
    rd_chk("pop_77", 16'h0020, 64'h77);
    cycle(1'b1, 16'h0030, 64'h99, 1'b1, 16'h0030, 9'h011, v, d, t);
    check("oow_valid", 64'(v), 64'd0);
    check("oow_count", 64'(count), 64'd0);

    // push+pop on empty, then flush+pop, then flush with flag clear
    cycle(1'b1, 16'h0020, 64'h66, 1'b1, 16'h0020, 9'h044, v, d, t);
    check("emptypp_data", d, 64'h0);
    check("emptypp_count", 64'(count), 64'd1);
    wr(16'h0020, 64'h9A);
    cycle(1'b1, 16'h0024, 64'h1, 1'b1, 16'h0020, 9'h055, v, d, t);
    check("flushpop_data", d, 64'h66);
    check("flushpop_count", 64'(count), 64'd0);
    rd_chk("st_flush_keep", 16'h0022, 64'h0000_0008_0009_0000);
    wr(16'h0024, 64'h3);
    rd_chk("st_both", 16'h0022, ST_EMPTY);

    // reset mid-operation wins
    wr(16'h0020, 64'h12);
    @(negedge clk);
    rst = 1'b1; rd_valid = 1'b1; rd_addr = 16'h0022; wr_valid = 1'b1; wr_addr = 16'h0020;
    @(posedge clk); #1;
    rst = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0;
    check("rstmid_valid", 64'(rd_resp_valid), 64'd0);
    check("rstmid_count", 64'(count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
